dcache_responder: RTL and testbench

//  Data-cache responder serving the memory stage's cache request interface (enable/wr_en/addr/value in,

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_responder_if.sv | 35 +++
 rtl/dcache_array.sv | 51 +++++
 rtl/dcache_responder.sv | 170 +++++++++++++++++
 tb/tb_dcache_responder.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared state encoding, bus request record and address-field helpers for the data-cache responder.
package dcache_pkg;

    localparam int DEF_NUM_LINES  = 64;
    localparam int DEF_LINE_WORDS = 8;
    localparam int WORD_OFF       = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL_REQ,
        REFILL_DATA,
        WRITE_REQ,
        RESPOND,
        DRAIN
    } state_t;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } mem_req_t;

    function automatic int tag_width(input int lines, input int words);
        return 64 - WORD_OFF - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// Memory-stage request port plus memory-bus port of the data-cache responder.
// master = responder side, slave = memory stage / bus side.
interface dcache_responder_if;

    logic        cache_enable;
    logic        cache_wr_en;
    logic [63:0] cache_wr_addr;
    logic [63:0] cache_rd_addr;
    logic [63:0] cache_wr_value;
    logic [63:0] cache_data;
    logic        cache_operation_complete;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;

    modport master (
        input  cache_enable, cache_wr_en, cache_wr_addr, cache_rd_addr, cache_wr_value,
        output cache_data, cache_operation_complete,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        output cache_enable, cache_wr_en, cache_wr_addr, cache_rd_addr, cache_wr_value,
        input  cache_data, cache_operation_complete,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/dcache_array.sv
// Tag/valid/data storage: combinational read of one word, synchronous single-word write.
// Latency: read 0 cycles, write 1 cycle; no backpressure (always accepts).
module dcache_array #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 8,
    parameter int TAG_W      = 52,
    parameter int IDX_W      = $clog2(NUM_LINES),
    parameter int WORD_W     = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              clear_all,
    input  logic [IDX_W-1:0]  rd_index,
    input  logic [WORD_W-1:0] rd_word,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [63:0]       rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [63:0]       wr_data,
    input  logic              set_valid,
    input  logic [TAG_W-1:0]  set_tag
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [63:0]          data_q [NUM_LINES*LINE_WORDS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[{rd_index, rd_word}];

    always_ff @(posedge clk) begin
        if (clear_all) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tags and data need no reset: valid gates every use of them.
    always_ff @(posedge clk) begin
        if (set_valid) begin
            tag_q[wr_index] <= set_tag;
        end
        if (wr_en) begin
            data_q[{wr_index, wr_word}] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-through no-allocate D-cache; load hit completes 2 cycles after enable.
// Bus request held until ready; refill beats accepted whenever resp_valid; one completion per request.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = DEF_NUM_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic               clk,
    input  logic               rst,
    dcache_responder_if.master io
);

    localparam int WB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(NUM_LINES);
    localparam int TB = tag_width(NUM_LINES, LINE_WORDS);
    localparam logic [WB-1:0] LAST_BEAT = WB'(LINE_WORDS - 1);

    state_t      state;
    logic        cap_we;
    logic [63:0] cap_addr;
    logic [63:0] cap_value;
    logic [WB-1:0] beat;
    logic [63:0] beat_word;
    logic [63:0] data_q;
    logic        complete_q;
    logic        req_valid_q;
    mem_req_t    req_q;

    logic [WB-1:0] cap_word;
    logic [IB-1:0] cap_idx;
    logic [TB-1:0] cap_tag;
    assign cap_word = cap_addr[WORD_OFF +: WB];
    assign cap_idx  = cap_addr[WORD_OFF + WB +: IB];
    assign cap_tag  = cap_addr[63 -: TB];

    logic          rd_valid;
    logic [TB-1:0] rd_tag;
    logic [63:0]   rd_data;
    logic          hit;
    assign hit = rd_valid && (rd_tag == cap_tag);

    logic          arr_we;
    logic [WB-1:0] arr_word;
    logic [63:0]   arr_data;
    logic          set_valid;

    // Store hits update the line during LOOKUP; refill beats land at the beat counter.
    always_comb begin
        arr_we    = 1'b0;
        arr_word  = cap_word;
        arr_data  = cap_value;
        set_valid = 1'b0;
        if (state == LOOKUP && cap_we && hit) begin
            arr_we = 1'b1;
        end else if (state == REFILL_DATA && io.mem_resp_valid) begin
            arr_we    = 1'b1;
            arr_word  = beat;
            arr_data  = io.mem_resp_data;
            set_valid = (beat == LAST_BEAT);
        end
    end

    dcache_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TB)
    ) u_array (
        .clk       (clk),
        .clear_all (rst),
        .rd_index  (cap_idx),
        .rd_word   (cap_word),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (arr_we),
        .wr_index  (cap_idx),
        .wr_word   (arr_word),
        .wr_data   (arr_data),
        .set_valid (set_valid),
        .set_tag   (cap_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cap_we      <= 1'b0;
            cap_addr    <= '0;
            cap_value   <= '0;
            beat        <= '0;
            beat_word   <= '0;
            data_q      <= '0;
            complete_q  <= 1'b0;
            req_valid_q <= 1'b0;
            req_q       <= '0;
        end else begin
            complete_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.cache_enable) begin
                        cap_we    <= io.cache_wr_en;
                        cap_addr  <= io.cache_wr_en ? io.cache_wr_addr : io.cache_rd_addr;
                        cap_value <= io.cache_wr_value;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (cap_we) begin
                        req_valid_q <= 1'b1;
                        req_q       <= '{we: 1'b1, addr: cap_addr, wdata: cap_value};
                        state       <= WRITE_REQ;
                    end else if (hit) begin
                        data_q     <= rd_data;
                        complete_q <= 1'b1;
                        state      <= RESPOND;
                    end else begin
                        req_valid_q <= 1'b1;
                        req_q       <= '{we: 1'b0,
                                         addr: {cap_addr[63:WORD_OFF+WB], {(WORD_OFF+WB){1'b0}}},
                                         wdata: 64'd0};
                        state       <= REFILL_REQ;
                    end
                end
                REFILL_REQ: begin
                    if (io.mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        beat        <= '0;
                        state       <= REFILL_DATA;
                    end
                end
                REFILL_DATA: begin
                    if (io.mem_resp_valid) begin
                        beat <= beat + 1'b1;
                        if (beat == cap_word) begin
                            beat_word <= io.mem_resp_data;
                        end
                        // cache_data only changes on entry to RESPOND, so pick the word here.
                        if (beat == LAST_BEAT) begin
                            data_q     <= (beat == cap_word) ? io.mem_resp_data : beat_word;
                            complete_q <= 1'b1;
                            state      <= RESPOND;
                        end
                    end
                end
                WRITE_REQ: begin
                    if (io.mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        complete_q  <= 1'b1;
                        state       <= RESPOND;
                    end
                end
                RESPOND: state <= DRAIN;
                DRAIN: begin
                    if (!io.cache_enable) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.cache_data               = data_q;
    assign io.cache_operation_complete = complete_q;
    assign io.mem_req_valid            = req_valid_q;
    assign io.mem_req_we               = req_q.we;
    assign io.mem_req_addr             = req_q.addr;
    assign io.mem_req_wdata            = req_q.wdata;

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: directed vector table, reset-mid-refill sequence, random traffic vs set-residency model.
module tb_dcache_responder;

    localparam int NL         = 64;
    localparam int LW         = 8;
    localparam int LINE_BYTES = LW * 8;
    localparam int MAXC       = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_responder_if io();

    dcache_responder #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Backing memory seen by the bus: word-addressed, unwritten words follow a hash pattern.
    logic [63:0] mem_m [longint unsigned];

    function automatic logic [63:0] dflt(input logic [63:0] a);
        return ((a >> 3) * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (mem_m.exists(a >> 3)) return mem_m[a >> 3];
        return dflt(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    logic [63:0] r_data, r_data_after, r_rd_addr, r_wr_addr, r_wr_data;
    int          r_ncomp, r_nrd, r_nwr, r_lat;
    bit          r_proto, r_done;

    // Acts as memory stage and bus for one request; records what the DUT did.
    task automatic run_op(input bit we, input logic [63:0] addr, input logic [63:0] val,
                          input int rdy_dly, input int hold, input bit gaps);
        int wait_cnt, beats_left, beat_i, drop_at, after;
        bit dropped, fin, vld_pend;
        logic [63:0] line_base, f_addr, f_wdata;
        logic f_we;
        wait_cnt = 0; beats_left = 0; beat_i = 0; drop_at = -1; after = 0;
        dropped = 0; fin = 0; vld_pend = 0; line_base = '0;
        f_addr = '0; f_wdata = '0; f_we = 1'b0;
        r_data = '0; r_data_after = '0; r_rd_addr = '0; r_wr_addr = '0; r_wr_data = '0;
        r_ncomp = 0; r_nrd = 0; r_nwr = 0; r_lat = -1; r_proto = 0; r_done = 0;
        @(negedge clk);
        io.cache_enable   = 1'b1;
        io.cache_wr_en    = we;
        io.cache_wr_addr  = we ? addr : {$urandom, $urandom};
        io.cache_rd_addr  = we ? {$urandom, $urandom} : addr;
        io.cache_wr_value = val;
        for (int cyc = 1; cyc <= MAXC && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                io.cache_wr_en    = 1'($urandom);
                io.cache_wr_addr  = {$urandom, $urandom};
                io.cache_rd_addr  = {$urandom, $urandom};
                io.cache_wr_value = {$urandom, $urandom};
            end
            io.mem_req_ready  = 1'b0;
            io.mem_resp_valid = 1'b0;
            if (io.cache_operation_complete) begin
                r_ncomp++;
                if (r_ncomp == 1) begin
                    r_lat   = cyc;
                    r_data  = io.cache_data;
                    drop_at = cyc + hold;
                end
            end
            if (vld_pend && !io.mem_req_valid) r_proto = 1;
            if (beats_left > 0) begin
                if (!(gaps && $urandom_range(0, 2) == 0)) begin
                    io.mem_resp_valid = 1'b1;
                    io.mem_resp_data  = mem_rd(line_base + 64'(8 * beat_i));
                    beat_i++;
                    beats_left--;
                end
            end else if (io.mem_req_valid) begin
                if (!vld_pend) begin
                    f_we = io.mem_req_we; f_addr = io.mem_req_addr; f_wdata = io.mem_req_wdata;
                    vld_pend = 1;
                end else if (f_we !== io.mem_req_we || f_addr !== io.mem_req_addr ||
                             f_wdata !== io.mem_req_wdata) begin
                    r_proto = 1;
                end
                if (wait_cnt >= rdy_dly) begin
                    io.mem_req_ready = 1'b1;
                    vld_pend = 0;
                    wait_cnt = 0;
                    if (io.mem_req_we) begin
                        r_nwr++;
                        r_wr_addr = io.mem_req_addr;
                        r_wr_data = io.mem_req_wdata;
                        mem_m[io.mem_req_addr >> 3] = io.mem_req_wdata;
                    end else begin
                        r_nrd++;
                        r_rd_addr  = io.mem_req_addr;
                        line_base  = io.mem_req_addr;
                        beats_left = LW;
                        beat_i     = 0;
                    end
                end else begin
                    wait_cnt++;
                end
            end
            if (dropped) begin
                after++;
                if (after > 4) fin = 1;
            end
            if (cyc == drop_at) begin
                io.cache_enable = 1'b0;
                dropped = 1;
            end
        end
        r_done = fin;
        r_data_after = io.cache_data;
        io.mem_req_ready  = 1'b0;
        io.mem_resp_valid = 1'b0;
    endtask

    task automatic check_op(input string tag, input bit we, input logic [63:0] addr,
                            input logic [63:0] val, input logic [63:0] exp_data,
                            input int exp_rd, input logic [63:0] exp_rd_addr, input int exp_lat);
        chk({tag, ".done"}, 64'(r_done), 64'd1);
        chk({tag, ".ncomplete"}, 64'(r_ncomp), 64'd1);
        chk({tag, ".bus_proto"}, 64'(r_proto), 64'd0);
        chk({tag, ".nread"}, 64'(r_nrd), 64'(exp_rd));
        chk({tag, ".nwrite"}, 64'(r_nwr), 64'(we));
        if (we) begin
            chk({tag, ".wr_addr"}, r_wr_addr, addr);
            chk({tag, ".wr_data"}, r_wr_data, val);
        end else begin
            chk({tag, ".data"}, r_data, exp_data);
            chk({tag, ".data_hold"}, r_data_after, exp_data);
        end
        if (exp_rd > 0) chk({tag, ".rd_addr"}, r_rd_addr, exp_rd_addr);
        if (exp_lat >= 0) chk({tag, ".latency"}, 64'(r_lat), 64'(exp_lat));
    endtask

    typedef struct {
        bit          we;
        logic [63:0] addr;
        logic [63:0] val;
        int          dly;
        int          hold;
        logic [63:0] exp_data;
        int          exp_rd;
        logic [63:0] exp_rd_addr;
        int          exp_lat;
    } vec_t;

    vec_t vt[10];

    longint unsigned resident [int];
    logic [63:0] pool [6];

    initial begin
        bit got;
        logic [63:0] a, v, line, exp;
        int idx;
        bit we, hit;

        rst = 1'b1;
        io.cache_enable = 0; io.cache_wr_en = 0; io.cache_wr_addr = 0; io.cache_rd_addr = 0;
        io.cache_wr_value = 0; io.mem_req_ready = 0; io.mem_resp_valid = 0; io.mem_resp_data = 0;
        for (int k = 0; k < LW; k++) mem_m[(64'h1000 >> 3) + k] = 64'hA0 + 64'(k);
        repeat (3) @(negedge clk);
        chk("reset.complete", 64'(io.cache_operation_complete), 64'd0);
        chk("reset.req_valid", 64'(io.mem_req_valid), 64'd0);
        chk("reset.data", io.cache_data, 64'd0);
        chk("reset.req_addr", io.mem_req_addr, 64'd0);
        rst = 1'b0;

        //        we  addr          value          dly hold exp_data        rd  rd_addr       lat
        vt[0] = '{0, 64'h1000, 64'h0,    0, 0, 64'hA0,       1, 64'h1000, -1};
        vt[1] = '{0, 64'h1008, 64'h0,    0, 0, 64'hA1,       0, 64'h0,     2};
        vt[2] = '{1, 64'h1010, 64'hDEAD, 3, 0, 64'h0,        0, 64'h0,    -1};
        vt[3] = '{0, 64'h1010, 64'h0,    0, 0, 64'hDEAD,     0, 64'h0,     2};
        vt[4] = '{1, 64'h8000, 64'h55,   0, 0, 64'h0,        0, 64'h0,    -1};
        vt[5] = '{0, 64'h8000, 64'h0,    1, 0, 64'h55,       1, 64'h8000, -1};
        vt[6] = '{0, 64'h1000, 64'h0,    0, 0, 64'hA0,       1, 64'h1000, -1};
        vt[7] = '{0, 64'h1000 + NL*LINE_BYTES, 64'h0, 0, 0, dflt(64'h1000 + NL*LINE_BYTES),
                  1, 64'h1000 + NL*LINE_BYTES, -1};
        vt[8] = '{0, 64'h1000, 64'h0,    0, 0, 64'hA0,       1, 64'h1000, -1};
        vt[9] = '{0, 64'h1008, 64'h0,    0, 3, 64'hA1,       0, 64'h0,     2};

        for (int i = 0; i < 10; i++) begin
            run_op(vt[i].we, vt[i].addr, vt[i].val, vt[i].dly, vt[i].hold, 1'b0);
            check_op($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].val, vt[i].exp_data,
                     vt[i].exp_rd, vt[i].exp_rd_addr, vt[i].exp_lat);
        end

        // Reset in the middle of a refill, then stray beats while idle.
        @(negedge clk);
        io.cache_enable = 1'b1; io.cache_wr_en = 1'b0; io.cache_rd_addr = 64'h3000;
        got = 0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (io.mem_req_valid) got = 1;
        end
        chk("rstmid.req_seen", 64'(got), 64'd1);
        io.mem_req_ready = 1'b1;
        @(negedge clk);
        io.mem_req_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            io.mem_resp_valid = 1'b1;
            io.mem_resp_data  = mem_rd(64'h3000 + 64'(8 * b));
            @(negedge clk);
        end
        io.mem_resp_valid = 1'b0;
        io.cache_enable   = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid.complete", 64'(io.cache_operation_complete), 64'd0);
        chk("rstmid.req_valid", 64'(io.mem_req_valid), 64'd0);
        chk("rstmid.data", io.cache_data, 64'd0);
        chk("rstmid.req_addr", io.mem_req_addr, 64'd0);
        rst = 1'b0;
        io.mem_resp_valid = 1'b1;
        io.mem_resp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        repeat (2) @(negedge clk);
        io.mem_resp_valid = 1'b0;
        run_op(1'b0, 64'h1000, 64'h0, 0, 0, 1'b0);
        check_op("rstmid.reload", 1'b0, 64'h1000, 64'h0, 64'hA0, 1, 64'h1000, -1);

        // Random traffic over a few conflicting lines, checked against set residency.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        resident.delete();
        pool = '{64'h1000, 64'h2000, 64'h1040, 64'h5040, 64'h7FC0, 64'h3FFC0};
        for (int i = 0; i < 120; i++) begin
            a    = pool[$urandom_range(0, 5)] + 64'($urandom_range(0, LINE_BYTES - 1));
            we   = ($urandom_range(0, 2) == 0);
            v    = {$urandom, $urandom};
            line = a / LINE_BYTES;
            idx  = int'(line % NL);
            hit  = resident.exists(idx) && resident[idx] == line;
            exp  = mem_rd(a);
            run_op(we, a, v, $urandom_range(0, 3), $urandom_range(0, 2), 1'b1);
            if (!we && !hit) resident[idx] = line;
            check_op($sformatf("rnd%0d", i), we, a, v, exp, (!we && !hit) ? 1 : 0,
                     a & ~64'(LINE_BYTES - 1), (!we && hit) ? 2 : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
